seq_alu: RTL and testbench

//  Parametrised multi-cycle ALU for the APCPU datapath; successor of the 32-bit combinational ALU.

---
 rtl/seq_alu_if.sv | 35 +++
 rtl/seq_alu.sv | 236 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and data bundle for seq_alu: operand/selector request channel
// and result/flag response channel, each with its own valid/ready pair.
interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [SEL_W-1:0] alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             div_zero;
  logic             illegal;

  // ALU side
  modport slave (
    input  in_valid, op_a, op_b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out,
    output carry_out, zero, negative, overflow, div_zero, illegal
  );

  // Requester / consumer side
  modport master (
    output in_valid, op_a, op_b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out,
    input  carry_out, zero, negative, overflow, div_zero, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and
// restoring DIVU/REMU. Results and flags are registered and held in DONE
// until the consumer takes them; a new op may be accepted on that same edge.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [SEL_W-1:0] OP_NOP  = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SLL  = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SRL  = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SRA  = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_SLT  = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_SLTU = SEL_W'(10);
  localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(11);
  localparam logic [SEL_W-1:0] OP_DIVU = SEL_W'(12);
  localparam logic [SEL_W-1:0] OP_REMU = SEL_W'(13);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  // Iteration state for MUL / DIVU / REMU
  logic [SH_W-1:0]  r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [WIDTH-1:0] r_acc;    // MUL partial product / DIV partial remainder
  logic [WIDTH-1:0] r_mcand;  // MUL multiplicand, shifted left each step
  logic [WIDTH-1:0] r_y;      // MUL multiplier (shifts right) / DIV dividend-in, quotient-out
  logic [WIDTH-1:0] r_div;    // DIV divisor

  // Registered result and flags
  logic [WIDTH-1:0] r_alu_out;
  logic             r_carry;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic             r_divz;
  logic             r_ill;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_multi;
  logic             w_last;

  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic             w_ill;

  logic [WIDTH-1:0] w_mul_acc_next;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_rem_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_fin_res;

  // Ready only in IDLE, or in DONE when the held result is being taken this edge
  assign w_in_ready = rst_n && ((r_state == S_IDLE) ||
                                ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_multi    = (bus.alu_sel == OP_MUL) || (bus.alu_sel == OP_DIVU) ||
                      (bus.alu_sel == OP_REMU);
  assign w_last     = (r_state == S_BUSY) && (r_cnt == SH_W'(WIDTH - 1));
  assign w_shamt    = bus.op_b[SH_W-1:0];

  // Single-cycle result and ADD/SUB flags straight from the request inputs
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (bus.alu_sel)
      OP_NOP: w_res = '0;
      OP_ADD: begin
        w_sum   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                  (w_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + (WIDTH+1)'(1);
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                  (w_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_AND:  w_res = bus.op_a & bus.op_b;
      OP_OR:   w_res = bus.op_a | bus.op_b;
      OP_XOR:  w_res = bus.op_a ^ bus.op_b;
      OP_SLL:  w_res = bus.op_a << w_shamt;
      OP_SRL:  w_res = bus.op_a >> w_shamt;
      OP_SRA:  w_res = $signed(bus.op_a) >>> w_shamt;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, bus.op_a < bus.op_b};
      OP_MUL, OP_DIVU, OP_REMU: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // One shift-add / restoring-divide step, plus the value to publish on the last step
  always_comb begin
    w_mul_acc_next = r_y[0] ? (r_acc + r_mcand) : r_acc;
    w_rem_shift    = {r_acc, r_y[WIDTH-1]};
    w_rem_ge       = (w_rem_shift >= {1'b0, r_div});
    // Difference is below the divisor whenever it is used, so WIDTH bits suffice
    w_rem_sub      = w_rem_shift[WIDTH-1:0] - r_div;
    w_rem_next     = w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
    w_quo_next     = {r_y[WIDTH-2:0], w_rem_ge};
    w_fin_res      = w_mul_acc_next;
    if (r_sel == OP_DIVU) begin
      w_fin_res = w_quo_next;
    end else if (r_sel == OP_REMU) begin
      w_fin_res = w_rem_next;
    end
  end

  // Next-state logic for IDLE / BUSY / DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_multi ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (w_accept) begin
            w_state_next = w_multi ? S_BUSY : S_DONE;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load operands for an iterative op, then advance one step per cycle while BUSY
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_y     <= '0;
      r_div   <= '0;
    end else if (w_accept && w_multi) begin
      r_cnt   <= '0;
      r_sel   <= bus.alu_sel;
      r_acc   <= '0;
      r_mcand <= bus.op_a;
      r_y     <= (bus.alu_sel == OP_MUL) ? bus.op_b : bus.op_a;
      r_div   <= bus.op_b;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + SH_W'(1);
      if (r_sel == OP_MUL) begin
        r_acc   <= w_mul_acc_next;
        r_mcand <= r_mcand << 1;
        r_y     <= r_y >> 1;
      end else begin
        r_acc <= w_rem_next;
        r_y   <= w_quo_next;
      end
    end
  end

  // Publish result/flags on single-cycle accept or on the last iteration; hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_out <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_divz    <= 1'b0;
      r_ill     <= 1'b0;
    end else if (w_accept && !w_multi) begin
      r_alu_out <= w_res;
      r_carry   <= w_carry;
      r_zero    <= (w_res == '0);
      r_neg     <= w_res[WIDTH-1];
      r_ovf     <= w_ovf;
      r_divz    <= 1'b0;
      r_ill     <= w_ill;
    end else if (w_last) begin
      r_alu_out <= w_fin_res;
      r_carry   <= 1'b0;
      r_zero    <= (w_fin_res == '0);
      r_neg     <= w_fin_res[WIDTH-1];
      r_ovf     <= 1'b0;
      r_divz    <= (r_sel != OP_MUL) && (r_div == '0);
      r_ill     <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.alu_out   = r_alu_out;
  assign bus.carry_out = r_carry;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_neg;
  assign bus.overflow  = r_ovf;
  assign bus.div_zero  = r_divz;
  assign bus.illegal   = r_ill;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed results/flags, handshake timing,
// back-pressure, streaming throughput and reset abort.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail = 0;
  logic bad;

  seq_alu_if #(.WIDTH(32), .SEL_W(8)) bus ();

  seq_alu #(.WIDTH(32), .SEL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {carry, zero, negative, overflow, div_zero, illegal}
  logic [5:0] flags;
  assign flags = {bus.carry_out, bus.zero, bus.negative, bus.overflow,
                  bus.div_zero, bus.illegal};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [7:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_sel  = sel;
    bus.op_a     = a;
    bus.op_b     = b;
    #1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [31:0] res, input logic [5:0] fl);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_out"}, bus.alu_out, res);
    chk({tag, "_flags"}, {26'd0, flags}, {26'd0, fl});
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_consumed"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic single(input string tag, input logic [7:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [5:0] fl);
    issue(tag, sel, a, b);
    check_res(tag, res, fl);
    consume(tag);
  endtask

  // Iterative op: out_valid must stay low (and in_ready low) for 32 edges after accept
  task automatic multi(input string tag, input logic [7:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic [5:0] fl);
    logic busy_bad;
    issue(tag, sel, a, b);
    busy_bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) busy_bad = 1'b1;
      step();
    end
    chk({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
    check_res(tag, res, fl);
    consume(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_sel   = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    step();
    step();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_alu_out", bus.alu_out, 32'd0);
    chk("rst_flags", {26'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single-cycle ops
    single("add_wrap", 8'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 6'b110000);
    single("sub_ovf", 8'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 6'b100100);
    single("sub_eq", 8'd2, 32'h5, 32'h5, 32'h0, 6'b110000);
    single("slt", 8'd9, 32'hFFFF_FFFF, 32'h0, 32'h1, 6'b000000);
    single("sltu", 8'd10, 32'hFFFF_FFFF, 32'h0, 32'h0, 6'b010000);
    single("and", 8'd3, 32'hF0F0, 32'hFF00, 32'hF000, 6'b000000);
    single("or", 8'd4, 32'hF0F0, 32'h0F0F, 32'hFFFF, 6'b000000);
    single("xor", 8'd5, 32'hFFFF, 32'h00FF, 32'hFF00, 6'b000000);
    single("sll_mask", 8'd6, 32'h1, 32'h21, 32'h2, 6'b000000);
    single("srl", 8'd7, 32'h8000_0000, 32'h4, 32'h0800_0000, 6'b000000);
    single("sra", 8'd8, 32'h8000_0000, 32'h4, 32'hF800_0000, 6'b001000);
    single("nop", 8'd0, 32'h123, 32'h456, 32'h0, 6'b010000);
    single("ill_ff", 8'hFF, 32'h1, 32'h2, 32'h0, 6'b010001);
    single("ill_14", 8'd14, 32'h7, 32'h7, 32'h0, 6'b010001);

    // Iterative ops
    multi("mul", 8'd11, 32'h0001_0003, 32'h5, 32'h0005_000F, 6'b000000);
    multi("mul_ones", 8'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 6'b000000);
    multi("divu", 8'd12, 32'd100, 32'd7, 32'd14, 6'b000000);
    multi("remu", 8'd13, 32'd100, 32'd7, 32'd2, 6'b000000);
    multi("divu_z", 8'd12, 32'h1234, 32'h0, 32'hFFFF_FFFF, 6'b001010);
    multi("remu_z", 8'd13, 32'h1234, 32'h0, 32'h1234, 6'b000010);

    // Back-pressure: result held, pending request not taken
    issue("stall", 8'd1, 32'd5, 32'd7);
    check_res("stall", 32'd12, 6'b000000);
    bus.in_valid = 1'b1;
    bus.alu_sel  = 8'd1;
    bus.op_a     = 32'd1;
    bus.op_b     = 32'd1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.alu_out !== 32'd12 || flags !== 6'b000000 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    chk("stall_stable", {31'd0, bad}, 32'd0);

    // Streaming: one result per cycle with out_ready held high
    bus.out_ready = 1'b1;
    #1;
    chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    check_res("stream0", 32'd2, 6'b000000);
    bus.op_a = 32'd10;
    bus.op_b = 32'd20;
    step();
    check_res("stream1", 32'd30, 6'b000000);
    bus.op_a = 32'h7FFF_FFFF;
    bus.op_b = 32'd1;
    step();
    check_res("stream2", 32'h8000_0000, 6'b001100);
    bus.op_a = 32'd3;
    bus.op_b = 32'd4;
    step();
    check_res("stream3", 32'd7, 6'b000000);
    bus.in_valid = 1'b0;
    step();
    chk("stream_drain", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Reset during MUL iteration 10 aborts it
    issue("mul_abort", 8'd11, 32'd3, 32'd5);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_alu_out", bus.alu_out, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid !== 1'b0) bad = 1'b1;
    end
    chk("abort_no_output", {31'd0, bad}, 32'd0);
    single("add_after_rst", 8'd1, 32'd2, 32'd3, 32'd5, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
